jk_univ_reg: RTL and testbench

- Parametrised, multi-bit successor to the single-bit JK flip-flop.
- A WIDTH-bit register in which every bit behaves as a D, T, JK or SR flip-flop, selected by a run-time mode input.
- Adds clock enable, a parametrised reset value, a registered change pulse, and sticky detection of illegal SR inputs.
- Used as a generic state/flag register in sequential datapaths and as a teaching/verification vehicle for all flip-flop types.

---
 rtl/jk_univ_reg.sv | 124 ++++++++++++
 tb/tb_jk_univ_reg.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/jk_univ_reg.sv
// Multi-bit universal flip-flop register. Each bit acts as a D, T, JK or SR
// flip-flop selected at run time, with a change pulse and sticky SR-illegal tracking.
module jk_univ_reg #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             changed,
    output logic             sr_err,
    output logic [WIDTH-1:0] err_bits
);

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    // Next state of one bit; the illegal SR pair falls into the hold branch.
    function automatic logic next_bit(
        input logic [1:0] m,
        input logic       cur,
        input logic       pa,
        input logic       pb
    );
        logic nxt;
        nxt = cur;
        case (m)
            MODE_D:  nxt = pa;
            MODE_T:  nxt = cur ^ pa;
            MODE_JK: begin
                case ({pa, pb})
                    2'b00:   nxt = cur;
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    2'b11:   nxt = ~cur;
                    default: nxt = cur;
                endcase
            end
            MODE_SR: begin
                case ({pa, pb})
                    2'b00:   nxt = cur;
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    default: nxt = cur;
                endcase
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    logic [WIDTH-1:0] q_q,        q_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;
    logic             changed_q,  changed_d;
    logic             sr_err_q,   sr_err_d;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] illegal_s;

    // Per-bit next state and the mask of bits with an illegal SR pair this edge.
    always_comb begin
        next_s    = q_q;
        illegal_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            next_s[i] = next_bit(mode, q_q[i], a[i], b[i]);
        end
        if (en && (mode == MODE_SR)) begin
            illegal_s = a & b;
        end else begin
            illegal_s = {WIDTH{1'b0}};
        end
    end

    // Register update, change detect and sticky error; a fresh error beats err_clr.
    always_comb begin
        q_d        = q_q;
        changed_d  = 1'b0;
        err_bits_d = err_bits_q;
        sr_err_d   = sr_err_q;
        if (en) begin
            q_d       = next_s;
            changed_d = (next_s != q_q);
        end else begin
            q_d       = q_q;
            changed_d = 1'b0;
        end
        if (err_clr) begin
            err_bits_d = illegal_s;
            sr_err_d   = |illegal_s;
        end else begin
            err_bits_d = err_bits_q | illegal_s;
            sr_err_d   = sr_err_q | (|illegal_s);
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q        <= RST_VAL;
            changed_q  <= 1'b0;
            sr_err_q   <= 1'b0;
            err_bits_q <= {WIDTH{1'b0}};
        end else begin
            q_q        <= q_d;
            changed_q  <= changed_d;
            sr_err_q   <= sr_err_d;
            err_bits_q <= err_bits_d;
        end
    end

    assign q        = q_q;
    assign q_bar    = ~q_q;
    assign changed  = changed_q;
    assign sr_err   = sr_err_q;
    assign err_bits = err_bits_q;

endmodule

// File: tb/tb_jk_univ_reg.sv
// Self-checking bench for jk_univ_reg: vector table plus scoreboard queue,
// async reset corner and a WIDTH=1 instance.
module tb_jk_univ_reg;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr;
        logic [7:0] q;
        logic       ch;
        logic       se;
        logic [7:0] eb;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       ch;
        logic       se;
        logic [7:0] eb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       err_clr = 1'b0;
    logic [7:0] q, q_bar, err_bits;
    logic       changed, sr_err;

    logic       en1 = 1'b0;
    logic [1:0] mode1 = 2'b10;
    logic [0:0] a1 = 1'b0;
    logic [0:0] b1 = 1'b0;
    logic [0:0] q1, q1_bar, eb1;
    logic       ch1, se1;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];
    vec_t vecs [0:21];

    always #5 clk = ~clk;

    jk_univ_reg #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .err_clr(err_clr), .q(q), .q_bar(q_bar), .changed(changed),
        .sr_err(sr_err), .err_bits(err_bits)
    );

    jk_univ_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_w1 (
        .clk(clk), .rst(rst), .en(en1), .mode(mode1), .a(a1), .b(b1),
        .err_clr(1'b0), .q(q1), .q_bar(q1_bar), .changed(ch1),
        .sr_err(se1), .err_bits(eb1)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, " q"},        q,                 e.q);
        chk({tag, " q_bar"},    q_bar,             ~e.q);
        chk({tag, " changed"},  {7'd0, changed},   {7'd0, e.ch});
        chk({tag, " sr_err"},   {7'd0, sr_err},    {7'd0, e.se});
        chk({tag, " err_bits"}, err_bits,          e.eb);
    endtask

    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        @(negedge clk);
        en = v.en; mode = v.mode; a = v.a; b = v.b; err_clr = v.clr;
        e.q = v.q; e.ch = v.ch; e.se = v.se; e.eb = v.eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_all($sformatf("vec%0d", idx), e);
    endtask

    initial begin
        exp_t e;
        logic [1:0] jk1 [0:4];
        logic       q1e [0:4];
        logic       c1e [0:4];

        //           en    mode   a      b      clr   q      ch    se    eb
        vecs[0]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 2'b10, 8'hF0, 8'h0F, 1'b0, 8'hF0, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 2'b10, 8'hFF, 8'hFF, 1'b0, 8'h0F, 1'b1, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 2'b10, 8'h00, 8'h00, 1'b0, 8'h0F, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 2'b01, 8'h01, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 2'b01, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 2'b01, 8'h01, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 2'b01, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 2'b00, 8'h3C, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 2'b00, 8'hFF, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{1'b1, 2'b00, 8'h0F, 8'h00, 1'b0, 8'h0F, 1'b1, 1'b0, 8'h00};
        vecs[12] = '{1'b1, 2'b11, 8'h81, 8'h01, 1'b0, 8'h8F, 1'b1, 1'b1, 8'h01};
        vecs[13] = '{1'b1, 2'b11, 8'h00, 8'h00, 1'b0, 8'h8F, 1'b0, 1'b1, 8'h01};
        vecs[14] = '{1'b0, 2'b11, 8'h00, 8'h00, 1'b1, 8'h8F, 1'b0, 1'b0, 8'h00};
        vecs[15] = '{1'b1, 2'b11, 8'h10, 8'h10, 1'b1, 8'h8F, 1'b0, 1'b1, 8'h10};
        vecs[16] = '{1'b1, 2'b11, 8'h01, 8'h01, 1'b0, 8'h8F, 1'b0, 1'b1, 8'h11};
        vecs[17] = '{1'b1, 2'b11, 8'h02, 8'h02, 1'b1, 8'h8F, 1'b0, 1'b1, 8'h02};
        vecs[18] = '{1'b1, 2'b11, 8'h70, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h02};
        vecs[19] = '{1'b1, 2'b11, 8'h00, 8'hF0, 1'b0, 8'h0F, 1'b1, 1'b1, 8'h02};
        vecs[20] = '{1'b0, 2'b11, 8'hFF, 8'hFF, 1'b0, 8'h0F, 1'b0, 1'b1, 8'h02};
        vecs[21] = '{1'b1, 2'b10, 8'hFF, 8'hFF, 1'b0, 8'hF0, 1'b1, 1'b1, 8'h02};

        jk1[0] = 2'b00; q1e[0] = 1'b0; c1e[0] = 1'b0;
        jk1[1] = 2'b01; q1e[1] = 1'b0; c1e[1] = 1'b0;
        jk1[2] = 2'b10; q1e[2] = 1'b1; c1e[2] = 1'b1;
        jk1[3] = 2'b11; q1e[3] = 1'b0; c1e[3] = 1'b1;
        jk1[4] = 2'b11; q1e[4] = 1'b1; c1e[4] = 1'b1;

        // Reset held across two edges.
        e = '{8'hA5, 1'b0, 1'b0, 8'h00};
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", e);
        chk("w1 reset q", {7'd0, q1}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_release", e);

        for (int i = 0; i < 22; i++) begin
            apply(i, vecs[i]);
        end

        // Asynchronous reset mid-cycle, checked before the next rising edge.
        @(negedge clk);
        en = 1'b1; mode = 2'b00; a = 8'h00; b = 8'h00; err_clr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        e = '{8'hA5, 1'b0, 1'b0, 8'h00};
        check_all("async_rst", e);
        @(posedge clk);
        #1;
        check_all("rst_hold", e);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b0;

        // WIDTH=1 instance in JK mode.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en1 = 1'b1; mode1 = 2'b10; a1 = jk1[i][1]; b1 = jk1[i][0];
            @(posedge clk);
            #1;
            chk($sformatf("w1 step%0d q", i),       {7'd0, q1},     {7'd0, q1e[i]});
            chk($sformatf("w1 step%0d q_bar", i),   {7'd0, q1_bar}, {7'd0, ~q1e[i]});
            chk($sformatf("w1 step%0d changed", i), {7'd0, ch1},    {7'd0, c1e[i]});
        end
        @(negedge clk);
        en1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
